fifo_merge_arbiter: RTL
=======================

FIFO_MERGE_ARBITER -- requirements
Module: fifo_merge_arbiter

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 6, giving the number of source FIFOs (1..16).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, giving the width of each source word.
REQ-003 The module SHALL have parameter MAX_BURST, default 1, giving the most consecutive words taken from one non-held channel before rotating (1..255).
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- BUS_CLK  in  1  sole clock; all logic on the rising edge.
- BUS_RST  in  1  reset.
- WRITE_REQ  in  CHANNELS  per-channel source not empty (first-word-fall-through).
- HOLD_REQ  in  CHANNELS  per-channel request to keep the grant.
- ENABLE  in  CHANNELS  per-channel participation mask.
- DATA_IN  in  CHANNELS*DATA_WIDTH  flattened source words; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- READ_GRANT  out  CHANNELS  one-hot pop strobe to the source, combinational.
- READY_IN  in  1  downstream accepts DATA_OUT this cycle.
- WRITE_OUT  out  1  DATA_OUT valid, registered.
- DATA_OUT  out  DATA_WIDTH  merged word, registered.
- DATA_CH  out  clog2(CHANNELS), minimum 1  source channel of DATA_OUT, registered.

Function
REQ-005 A downstream transfer SHALL occur in a cycle where WRITE_OUT=1 and READY_IN=1.
REQ-006 The output register SHALL be free in a cycle where WRITE_OUT=0 or READY_IN=1.
REQ-007 The selected channel k SHALL be eligible when WRITE_REQ[k]=1 and ENABLE[k]=1.
REQ-008 READ_GRANT[k] SHALL be 1 only when the output register is free and the selected channel k is eligible; at most one bit SHALL be set.
REQ-009 Latency SHALL be one cycle: DATA_IN[k], k and WRITE_OUT=1 SHALL be loaded on the edge ending a grant cycle.
REQ-010 When the register is free and no channel is granted, WRITE_OUT SHALL go to 0 on the next edge.
REQ-011 Selection SHALL be round-robin: the search starts at the channel after the last granted one, wraps from CHANNELS-1 to 0, and picks the first eligible channel.
REQ-012 The arbiter SHALL use FSM states IDLE, BURST and LOCK.
REQ-013 IDLE SHALL move to BURST on a grant, with the burst count set to 1.
REQ-014 BURST SHALL stay on the same channel while that channel is eligible, the count is below MAX_BURST and HOLD_REQ is 0; otherwise it SHALL rotate per REQ-011, and go to IDLE if no channel is eligible.
REQ-015 BURST or IDLE SHALL move to LOCK when HOLD_REQ[k]=1 on the currently granted channel k.
REQ-016 LOCK SHALL grant only channel k and ignore MAX_BURST.
- If k withdraws WRITE_REQ, LOCK SHALL issue no grants to any channel and SHALL stay in LOCK.
- LOCK SHALL exit to BURST-rotate when HOLD_REQ[k]=0 or ENABLE[k]=0.
REQ-017 HOLD_REQ on a channel that is not granted SHALL have no effect.
REQ-018 ENABLE[k] falling mid-burst SHALL let the word granted in that cycle complete; no further grant to k SHALL follow.
REQ-019 When WRITE_OUT=1 and READY_IN=0, DATA_OUT, DATA_CH and WRITE_OUT SHALL hold and READ_GRANT SHALL be all zero.
REQ-020 With CHANNELS=1, the arbiter SHALL degenerate to a registered pass-through with hold.

Reset
REQ-021 While BUS_RST=1, at the next edge:
- WRITE_OUT SHALL be 0, DATA_OUT 0 and DATA_CH 0;
- the FSM SHALL be in IDLE with the last-granted pointer at CHANNELS-1, so that channel 0 is searched first;
- the burst count SHALL be 0.
REQ-022 READ_GRANT SHALL be all zero while BUS_RST=1.
REQ-023 A word held in the output register at reset SHALL be discarded.

Configuration
REQ-024 With macro FIFO_MERGE_ARBITER_WORD_COUNT_EN defined, the module SHALL add output WORD_COUNT (CHANNELS*16).
- Each 16-bit field SHALL count that channel's downstream transfers.
- The counters SHALL saturate at 0xFFFF and be cleared by BUS_RST.
REQ-025 Without the macro, the port and its counters SHALL be absent, with no other change.

Structure
REQ-026 Shared package arb_pkg SHALL hold:
- the FSM state typedef (IDLE, BURST, LOCK);
- a clog2 constant function;
- the default CHANNELS, DATA_WIDTH and MAX_BURST constants.
REQ-027 One sub-module, rr_pick, SHALL implement the rotating-base priority encoder: request vector and base index in, one-hot result and index out, combinational.

Verification
REQ-028 The bench SHALL cover the following directed scenarios.
- Pure round-robin: CHANNELS=6, MAX_BURST=1, all WRITE_REQ=1, READY_IN=1 -> DATA_CH sequence 0,1,2,3,4,5,0 with one word per cycle after 1-cycle latency.
- Burst: MAX_BURST=4, channels 1 and 3 full -> DATA_CH 1,1,1,1,3,3,3,3,1.
- Lock: HOLD_REQ[0]=1 during the first grant to channel 0, WRITE_REQ[0] toggling -> only channel 0 words appear and gaps show WRITE_OUT=0; after HOLD_REQ[0]=0, the next word comes from channel 1.
- Backpressure: READY_IN=0 for 5 cycles with a word in the register -> DATA_OUT stable, READ_GRANT=0, no words lost or duplicated; the scoreboard matches the per-channel order.
- Mask/reset: ENABLE=6'b111110 -> channel 0 is never granted. BUS_RST asserted mid-stream -> next cycle WRITE_OUT=0, and the first grant after release goes to the lowest eligible channel.
- With FIFO_MERGE_ARBITER_WORD_COUNT_EN: 70000 transfers on channel 2 -> WORD_COUNT field 2 equals 0xFFFF and the other fields equal 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg -- shared definitions for the FIFO merge arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BURST, LOCK)
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, for index widths
//   DEF_*       : default CHANNELS / DATA_WIDTH / MAX_BURST
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2
  } arb_state_t;

  localparam int DEF_CHANNELS   = 6;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_BURST  = 1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- rotating-base priority encoder (combinational).
//   req    in  N   request vector
//   base   in  IW  index searched first; search wraps from N-1 to 0
//   onehot out N   one-hot of the first set request at or after base
//   idx    out IW  index of that request
//   any    out 1   at least one request set
module rr_pick #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  genvar gi;

  // Pick the request with the smallest wrapped distance from base.
  always_comb begin
    int best_d;
    int d;
    best_d = N;
    d      = 0;
    idx    = '0;
    any    = 1'b0;
    for (int j = 0; j < N; j++) begin
      d = j - int'(base);
      if (d < 0) d = d + N;
      if (req[j] && (d < best_d)) begin
        best_d = d;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot[gi] = any && (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/fifo_merge_arbiter.sv
// fifo_merge_arbiter -- merges CHANNELS first-word-fall-through sources into
// one registered stream with round-robin, burst and lock arbitration.
//   BUS_CLK, BUS_RST  clock, synchronous active-high reset
//   WRITE_REQ  in   per-channel source not empty
//   HOLD_REQ   in   per-channel request to keep the grant
//   ENABLE     in   per-channel participation mask
//   DATA_IN    in   flattened source words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   READ_GRANT out  one-hot pop strobe (combinational)
//   READY_IN   in   downstream accepts DATA_OUT
//   WRITE_OUT  out  DATA_OUT valid (registered)
//   DATA_OUT   out  merged word (registered)
//   DATA_CH    out  source channel of DATA_OUT (registered)
//   WORD_COUNT out  per-channel 16-bit saturating transfer counters, present
//                   only when FIFO_MERGE_ARBITER_WORD_COUNT_EN is defined
module fifo_merge_arbiter
  import arb_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  localparam int CW        = clog2_min1(CHANNELS)
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST,
  input  logic [CHANNELS-1:0]            WRITE_REQ,
  input  logic [CHANNELS-1:0]            HOLD_REQ,
  input  logic [CHANNELS-1:0]            ENABLE,
  input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
  output logic [CHANNELS-1:0]            READ_GRANT,
  input  logic                           READY_IN,
  output logic                           WRITE_OUT,
  output logic [DATA_WIDTH-1:0]          DATA_OUT,
`ifdef FIFO_MERGE_ARBITER_WORD_COUNT_EN
  output logic [CHANNELS*16-1:0]         WORD_COUNT,
`endif
  output logic [CW-1:0]                  DATA_CH
);

  genvar gi;

  arb_state_t            state_reg, state_next;
  logic [CW-1:0]         last_reg, last_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic                  write_out_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic [CW-1:0]         data_ch_reg;

  logic [CHANNELS-1:0]   eligible, last_sel, grant_vec, rr_vec;
  logic [CW-1:0]         base, grant_idx, rr_idx;
  logic                  free, rr_any, stay, lock_keep, grant_any, hold_on_grant;
  logic                  last_elig, last_hold, last_en;
  logic [DATA_WIDTH-1:0] sel_data;

  assign eligible = WRITE_REQ & ENABLE;
  assign free     = !write_out_reg || READY_IN;
  assign base     = (last_reg == CW'(CHANNELS - 1)) ? '0 : last_reg + CW'(1);

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_last_sel
      assign last_sel[gi] = (last_reg == CW'(gi));
    end
  endgenerate

  assign last_elig = |(eligible & last_sel);
  assign last_hold = |(HOLD_REQ & last_sel);
  assign last_en   = |(ENABLE & last_sel);

  rr_pick #(.N(CHANNELS), .IW(CW)) u_pick (
    .req    (eligible),
    .base   (base),
    .onehot (rr_vec),
    .idx    (rr_idx),
    .any    (rr_any)
  );

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    stay       = 1'b0;
    lock_keep  = 1'b0;
    case (state_reg)
      BURST:   stay      = last_elig && (cnt_reg < 8'(MAX_BURST)) && !last_hold;
      LOCK:    lock_keep = last_hold && last_en;
      default: ;
    endcase
    // A held channel that is momentarily empty gets no grant, and neither
    // does anyone else: the lock stays parked on it.
    if (stay || lock_keep) begin
      grant_any = last_elig;
      grant_vec = last_elig ? last_sel : '0;
      grant_idx = last_reg;
    end else begin
      grant_any = rr_any;
      grant_vec = rr_vec;
      grant_idx = rr_idx;
    end
    if (BUS_RST || !free) begin
      grant_any = 1'b0;
      grant_vec = '0;
    end
    hold_on_grant = |(HOLD_REQ & grant_vec);
    // Arbitration only advances when the output register can take a word.
    if (free && !BUS_RST) begin
      if (grant_any) begin
        last_next  = grant_idx;
        state_next = hold_on_grant ? LOCK : BURST;
        cnt_next   = stay ? cnt_reg + 8'd1 : 8'd1;
      end else if (!lock_keep) begin
        state_next = IDLE;
      end
    end
    READ_GRANT = grant_vec;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_vec[i]) sel_data = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_reg     <= IDLE;
      last_reg      <= CW'(CHANNELS - 1);
      cnt_reg       <= '0;
      write_out_reg <= 1'b0;
      data_out_reg  <= '0;
      data_ch_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      if (free) begin
        write_out_reg <= grant_any;
        if (grant_any) begin
          data_out_reg <= sel_data;
          data_ch_reg  <= grant_idx;
        end
      end
    end
  end

  assign WRITE_OUT = write_out_reg;
  assign DATA_OUT  = data_out_reg;
  assign DATA_CH   = data_ch_reg;

`ifdef FIFO_MERGE_ARBITER_WORD_COUNT_EN
  logic xfer;
  assign xfer = write_out_reg && READY_IN;

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_wc
      logic [15:0] wc_reg;
      always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
          wc_reg <= '0;
        end else if (xfer && (data_ch_reg == CW'(gi)) && (wc_reg != 16'hFFFF)) begin
          wc_reg <= wc_reg + 16'd1;
        end
      end
      assign WORD_COUNT[gi*16 +: 16] = wc_reg;
    end
  endgenerate
`endif

endmodule
